// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV64 pipeline: the execute-stage read port, the commit write port,
// mcycle/minstret, trap/mret state updates and the registered fetch redirect.
module csr_file #(
    parameter logic [63:0] MISA_VAL      = 64'h8000_0000_0014_1101,
    parameter logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888,
    parameter logic [63:0] MTVEC_RESET   = 64'h0,
    parameter bit          BYPASS        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rd_addr,
    output logic [63:0] rd_data,
    output logic        rd_illegal,
    input  logic        wr_valid,
    input  logic [11:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_cause,
    input  logic        mret_valid,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic [1:0]  priv
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_SATP     = 12'h180;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam int ST_MIE  = 3;
    localparam int ST_MPIE = 7;

    logic [63:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [63:0] mtval_q, mtval_d, mip_q, mip_d, satp_q, satp_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [1:0]  priv_q, priv_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;

    logic        wr_accept;
    logic [63:0] wr_value;
    logic [63:0] rd_value;
    logic [63:0] trap_target;

    function automatic logic is_writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
            A_MIP, A_SATP, A_MCYCLE, A_MINSTRET: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // A trap or mret in the same cycle swallows the commit write completely.
    assign wr_accept = wr_valid && !trap_valid && !mret_valid;

    always_comb begin
        case (wr_addr)
            A_MSTATUS: wr_value = (mstatus_q & ~MSTATUS_WMASK) | (wr_data & MSTATUS_WMASK);
            A_MTVEC:   wr_value = wr_data & ~64'h2;
            A_MEPC:    wr_value = wr_data & ~64'h3;
            default:   wr_value = wr_data;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        rd_value   = '0;
        rd_illegal = 1'b0;
        case (rd_addr)
            A_MSTATUS:  rd_value = mstatus_q;
            A_MISA:     rd_value = MISA_VAL;
            A_MIE:      rd_value = mie_q;
            A_MTVEC:    rd_value = mtvec_q;
            A_MSCRATCH: rd_value = mscratch_q;
            A_MEPC:     rd_value = mepc_q;
            A_MCAUSE:   rd_value = mcause_q;
            A_MTVAL:    rd_value = mtval_q;
            A_MIP:      rd_value = mip_q;
            A_SATP:     rd_value = satp_q;
            A_MCYCLE:   rd_value = mcycle_q;
            A_MINSTRET: rd_value = minstret_q;
            A_MHARTID:  rd_value = '0;
            default:    rd_illegal = 1'b1;
        endcase
    end

    assign rd_data = (BYPASS && wr_accept && (wr_addr == rd_addr) && is_writable(wr_addr))
                     ? wr_value : rd_value;

    // Vectored mode only applies to interrupts; exceptions always go to the base.
    assign trap_target = {mtvec_q[63:2], 2'b00} +
                         ((mtvec_q[0] && trap_cause[63]) ? {56'b0, trap_cause[5:0], 2'b00} : 64'b0);

    always_comb begin
        mstatus_d        = mstatus_q;
        mie_d            = mie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        mip_d            = mip_q;
        satp_d           = satp_q;
        mcycle_d         = mcycle_q + 64'd1;
        minstret_d       = retire ? minstret_q + 64'd1 : minstret_q;
        priv_d           = priv_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (trap_valid) begin
            mepc_d            = trap_pc & ~64'h3;
            mcause_d          = trap_cause;
            mstatus_d[ST_MPIE] = mstatus_q[ST_MIE];
            mstatus_d[ST_MIE]  = 1'b0;
            mstatus_d[12:11]   = priv_q;
            priv_d            = 2'd3;
            redirect_valid_d  = 1'b1;
            redirect_pc_d     = trap_target;
        end else if (mret_valid) begin
            priv_d             = mstatus_q[12:11];
            mstatus_d[ST_MIE]  = mstatus_q[ST_MPIE];
            mstatus_d[ST_MPIE] = 1'b1;
            mstatus_d[12:11]   = 2'd0;
            redirect_valid_d   = 1'b1;
            redirect_pc_d      = mepc_q;
        end else if (wr_accept) begin
            case (wr_addr)
                A_MSTATUS:  mstatus_d  = wr_value;
                A_MIE:      mie_d      = wr_value;
                A_MTVEC:    mtvec_d    = wr_value;
                A_MSCRATCH: mscratch_d = wr_value;
                A_MEPC:     mepc_d     = wr_value;
                A_MCAUSE:   mcause_d   = wr_value;
                A_MTVAL:    mtval_d    = wr_value;
                A_MIP:      mip_d      = wr_value;
                A_SATP:     satp_d     = wr_value;
                A_MCYCLE:   mcycle_d   = wr_value;
                A_MINSTRET: minstret_d = wr_value;
                default: ;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments only, and reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mstatus_q        <= '0;
            mie_q            <= '0;
            mtvec_q          <= MTVEC_RESET;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            mip_q            <= '0;
            satp_q           <= '0;
            mcycle_q         <= '0;
            minstret_q       <= '0;
            priv_q           <= 2'd3;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mstatus_q        <= mstatus_d;
            mie_q            <= mie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            mip_q            <= mip_d;
            satp_q           <= satp_d;
            mcycle_q         <= mcycle_d;
            minstret_q       <= minstret_d;
            priv_q           <= priv_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign priv           = priv_q;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: the driver predicts each cycle's outputs from a CSR-array model
// and queues them; a negedge monitor pops and compares against what the DUT presents.
module tb_csr_file;

    localparam logic [63:0] MISA_VAL      = 64'h8000_0000_0014_1101;
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
    localparam logic [63:0] MTVEC_RESET   = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_illegal;
    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic        retire;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic [63:0] trap_cause;
    logic        mret_valid;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  priv;

    always #5 clk = ~clk;

    csr_file #(
        .MISA_VAL(MISA_VAL), .MSTATUS_WMASK(MSTATUS_WMASK), .MTVEC_RESET(MTVEC_RESET), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .retire(retire),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause), .mret_valid(mret_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .priv(priv)
    );

    typedef struct {
        logic [11:0] addr;
        logic [63:0] rd_data;
        logic        rd_illegal;
        logic        rv;
        logic [63:0] rpc;
        logic [1:0]  priv;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the CSR space as a flat array plus privilege and redirect state.
    logic [63:0] m [4096];
    logic [1:0]  m_priv;
    logic        m_rv;
    logic [63:0] m_rpc;
    bit          armed = 1'b0;

    logic [11:0] addr_pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'h344, 12'h180, 12'hB00, 12'hB02,
                                    12'hF14, 12'h7C0, 12'h000, 12'hB01};

    function automatic bit impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'h344, 12'h180, 12'hB00, 12'hB02, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit writable(input logic [11:0] a);
        return impl(a) && a != 12'h301 && a != 12'hF14;
    endfunction

    function automatic logic [63:0] masked(input logic [11:0] a, input logic [63:0] d);
        case (a)
            12'h300: return (m[12'h300] & ~MSTATUS_WMASK) | (d & MSTATUS_WMASK);
            12'h305: return d & ~64'h2;
            12'h341: return d & ~64'h3;
            default: return d;
        endcase
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a);
        if (!impl(a)) return 64'h0;
        if (a == 12'h301) return MISA_VAL;
        if (a == 12'hF14) return 64'h0;
        return m[a];
    endfunction

    task automatic model_edge();
        logic [63:0] old_st, old_mepc, old_mtvec, st;
        if (!reset) begin
            foreach (m[i]) m[i] = 64'h0;
            m[12'h305] = MTVEC_RESET;
            m_priv = 2'd3;
            m_rv   = 1'b0;
            m_rpc  = 64'h0;
            return;
        end
        old_st    = m[12'h300];
        old_mepc  = m[12'h341];
        old_mtvec = m[12'h305];
        m[12'hB00] = m[12'hB00] + 64'd1;
        if (retire) m[12'hB02] = m[12'hB02] + 64'd1;
        m_rv = 1'b0;
        if (trap_valid) begin
            m[12'h341] = trap_pc & ~64'h3;
            m[12'h342] = trap_cause;
            st = old_st;
            st[7] = old_st[3];
            st[3] = 1'b0;
            st[12:11] = m_priv;
            m[12'h300] = st;
            m_priv = 2'd3;
            m_rv = 1'b1;
            m_rpc = (old_mtvec & ~64'h3) +
                    ((old_mtvec[0] && trap_cause[63]) ? (64'(trap_cause[5:0]) * 64'd4) : 64'd0);
        end else if (mret_valid) begin
            m_priv = old_st[12:11];
            st = old_st;
            st[3] = old_st[7];
            st[7] = 1'b1;
            st[12:11] = 2'd0;
            m[12'h300] = st;
            m_rv = 1'b1;
            m_rpc = old_mepc;
        end else if (wr_valid && writable(wr_addr)) begin
            m[wr_addr] = masked(wr_addr, wr_data);
        end
    endtask

    task automatic check(input string name, input logic [11:0] a,
                         input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s (addr %h) at %0t: got %h expected %h", name, a, $time, act, expv);
        end
    endtask

    task automatic idle();
        reset = 1'b1; rd_addr = 12'h300; wr_valid = 1'b0; wr_addr = 12'h0; wr_data = 64'h0;
        retire = 1'b0; trap_valid = 1'b0; trap_pc = 64'h0; trap_cause = 64'h0; mret_valid = 1'b0;
    endtask

    // Predict this cycle's outputs from the current inputs and model, then advance one edge.
    task automatic tick();
        exp_t e;
        if (armed) begin
            e.addr = rd_addr;
            e.rd_data = (wr_valid && !trap_valid && !mret_valid && wr_addr == rd_addr && writable(wr_addr))
                        ? masked(wr_addr, wr_data) : model_read(rd_addr);
            e.rd_illegal = !impl(rd_addr);
            e.rv   = m_rv;
            e.rpc  = m_rpc;
            e.priv = m_priv;
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_edge();
        if (!reset) armed = 1'b1;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        idle(); wr_valid = 1'b1; wr_addr = a; wr_data = d; rd_addr = a; tick();
    endtask

    task automatic rd(input logic [11:0] a);
        idle(); rd_addr = a; tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data", e.addr, rd_data, e.rd_data);
                check("rd_illegal", e.addr, 64'(rd_illegal), 64'(e.rd_illegal));
                check("redirect_valid", e.addr, 64'(redirect_valid), 64'(e.rv));
                check("priv", e.addr, 64'(priv), 64'(e.priv));
                if (e.rv) check("redirect_pc", e.addr, redirect_pc, e.rpc);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : driver
        idle();
        // Reset held for two edges, then mcycle counts up from zero.
        reset = 1'b0; rd_addr = 12'hB00; tick(); tick();
        repeat (5) rd(12'hB00);

        wr(12'h340, 64'hDEAD_BEEF); rd(12'h340);
        wr(12'h301, 64'h0); rd(12'h301); rd(12'h7C0); rd(12'hF14);

        wr(12'h300, 64'h8); wr(12'h305, 64'h8000_0100);
        idle(); trap_valid = 1'b1; trap_pc = 64'h8000_0042; trap_cause = 64'h2; tick();
        rd(12'h341); rd(12'h342); rd(12'h300);

        wr(12'h300, 64'h80);
        idle(); mret_valid = 1'b1; rd_addr = 12'h300; tick();
        rd(12'h300); rd(12'h304);

        idle(); trap_valid = 1'b1; trap_pc = 64'h8000_0203; trap_cause = 64'h5;
        wr_valid = 1'b1; wr_addr = 12'h341; wr_data = 64'h1234; rd_addr = 12'h341; tick();
        rd(12'h341);
        idle(); mret_valid = 1'b1; wr_valid = 1'b1; wr_addr = 12'h340; wr_data = 64'h55; rd_addr = 12'h340; tick();
        rd(12'h340);
        wr(12'hB00, 64'd100); rd(12'hB00); rd(12'hB00);

        wr(12'h305, 64'h1001);
        idle(); trap_valid = 1'b1; trap_pc = 64'h400; trap_cause = 64'h8000_0000_0000_0007; tick();
        idle(); trap_valid = 1'b1; trap_pc = 64'h404; trap_cause = 64'h7; tick();
        rd(12'h305); rd(12'h305);
        wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(); retire = 1'b1; rd_addr = 12'hB02; tick();
        rd(12'hB02);
        wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF); rd(12'hB00); rd(12'hB00);

        // Reset overrides a concurrent trap.
        idle(); reset = 1'b0; trap_valid = 1'b1; trap_pc = 64'h900; trap_cause = 64'h3; tick();
        rd(12'h341); rd(12'h305);

        for (int n = 0; n < 3000; n++) begin
            idle();
            reset      = ($urandom_range(0, 299) != 0);
            rd_addr    = addr_pool[$urandom_range(0, 15)];
            wr_valid   = ($urandom_range(0, 2) == 0);
            wr_addr    = ($urandom_range(0, 1) == 0) ? rd_addr : addr_pool[$urandom_range(0, 15)];
            wr_data    = {$urandom, $urandom};
            retire     = $urandom_range(0, 1) != 0;
            trap_valid = ($urandom_range(0, 15) == 0);
            trap_pc    = {$urandom, $urandom};
            trap_cause = {$urandom_range(0, 1) != 0, 57'h0, 6'($urandom_range(0, 63))};
            mret_valid = ($urandom_range(0, 15) == 0);
            tick();
        end

        idle();
        @(negedge clk);
        #1;
        check("scoreboard_drained", 12'h0, 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
